caudal_dosificador: RTL and testbench

Parametrised flow totalizer and dosing controller for the SCAAD flow-sensor path. It synchronises the raw flow-meter pulse and counts rising edges into a DIGITS-wide packed-BCD millilitre total, adding ML_PER_PULSE per edge with full decimal carry. A small FSM opens a valve output until the total reaches a BCD setpoint. The total feeds the display and the done flag feeds the system sequencer.

---
 rtl/caudal_pkg.sv | 33 +++
 rtl/bcd_digito_suma.sv | 18 +
 rtl/caudal_dosificador.sv | 140 ++++++++++++++
 tb/tb_caudal_dosificador.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/caudal_pkg.sv
// Shared types and helpers for the flow totalizer / dosing controller.
package caudal_pkg;
  typedef enum logic [1:0] {REPOSO, MIDIENDO, COMPLETO} estado_t;
  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_BASE = 5'd10;

  // Digit-lexicographic a >= b over the low n packed-BCD digits.
  function automatic logic bcd_ge(input logic [31:0] a, input logic [31:0] b, input int n);
    logic res, hecho;
    res   = 1'b1;
    hecho = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!hecho && i < n) begin
        if (a[i*4 +: 4] > b[i*4 +: 4]) begin
          res = 1'b1; hecho = 1'b1;
        end else if (a[i*4 +: 4] < b[i*4 +: 4]) begin
          res = 1'b0; hecho = 1'b1;
        end
      end
    end
    return res;
  endfunction

  function automatic logic bcd_valido(input logic [31:0] a, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (i < n && a[i*4 +: 4] > BCD_MAX) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bcd_digito_suma.sv
// One BCD digit of the ripple adder: digit + addend + carry_in, decimal carry out.
module bcd_digito_suma
  import caudal_pkg::*;
(
  input  bcd_t digit,
  input  bcd_t addend,
  input  logic carry_in,
  output bcd_t digit_out,
  output logic carry_out
);
  logic [4:0] s;

  always_comb begin
    s         = 5'(digit) + 5'(addend) + 5'(carry_in);
    carry_out = (s > 5'(BCD_MAX));
    digit_out = carry_out ? 4'(s - BCD_BASE) : s[3:0];
  end
endmodule

// File: rtl/caudal_dosificador.sv
// Flow totalizer (packed BCD) with valve dosing FSM.
// Optional pulse-rate window output enabled by CAUDAL_TASA_EN.
module caudal_dosificador
  import caudal_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int ML_PER_PULSE  = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int WINDOW_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulso_in,
  input  logic                borrar,
  input  logic                inicio,
  input  logic                detener,
  input  logic [4*DIGITS-1:0] consigna,
  output logic [4*DIGITS-1:0] mililitros,
  output logic                valvula,
  output logic                completo,
  output logic                desborde
`ifdef CAUDAL_TASA_EN
  ,
  output logic [15:0]         tasa
`endif
);
  localparam int W = 4 * DIGITS;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pulso_prev, evento;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      pulso_prev <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pulso_in};
      pulso_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evento = sync_q[SYNC_STAGES-1] & ~pulso_prev;

  // Ripple BCD increment; a carry out of the top digit means saturation.
  logic [DIGITS:0] carry;
  logic [W-1:0]    suma;
  assign carry[0] = 1'b0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digito_suma u_dig (
      .digit     (mililitros[g*4 +: 4]),
      .addend    ((g == 0) ? bcd_t'(ML_PER_PULSE) : bcd_t'(0)),
      .carry_in  (carry[g]),
      .digit_out (suma[g*4 +: 4]),
      .carry_out (carry[g+1])
    );
  end

  estado_t      estado, estado_nx;
  logic [W-1:0] setpoint;
  logic         arranque, alcanzado;

  assign arranque  = inicio && bcd_valido(32'(consigna), DIGITS) && (estado != MIDIENDO);
  assign alcanzado = bcd_ge(32'(mililitros), 32'(setpoint), DIGITS);

  always_comb begin
    estado_nx = estado;
    if (borrar)
      estado_nx = REPOSO;
    else if (arranque)
      estado_nx = (consigna == '0) ? COMPLETO : MIDIENDO;
    else if (detener && estado != REPOSO)
      estado_nx = REPOSO;
    else if (estado == MIDIENDO && (desborde || alcanzado))
      estado_nx = COMPLETO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= REPOSO;
      valvula  <= 1'b0;
      completo <= 1'b0;
    end else begin
      estado   <= estado_nx;
      valvula  <= (estado_nx == MIDIENDO);
      completo <= (estado_nx == COMPLETO);
    end
  end

  // Any inicio, accepted or not, swallows a coincident evento.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mililitros <= '0;
      desborde   <= 1'b0;
      setpoint   <= '0;
    end else if (borrar) begin
      mililitros <= '0;
      desborde   <= 1'b0;
    end else if (arranque) begin
      mililitros <= '0;
      desborde   <= 1'b0;
      setpoint   <= consigna;
    end else if (evento && !inicio) begin
      if (carry[DIGITS]) begin
        mililitros <= {DIGITS{BCD_MAX}};
        desborde   <= 1'b1;
      end else begin
        mililitros <= suma;
      end
    end
  end

`ifdef CAUDAL_TASA_EN
  localparam int WCW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [WCW-1:0] wcnt;
  logic [15:0]    pcnt, pcnt_inc;

  assign pcnt_inc = (evento && pcnt != 16'hFFFF) ? pcnt + 16'd1 : pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      pcnt <= '0;
      tasa <= '0;
    end else if (borrar) begin
      wcnt <= '0;
      pcnt <= '0;
      tasa <= '0;
    end else if (wcnt == WCW'(WINDOW_CYCLES - 1)) begin
      wcnt <= '0;
      pcnt <= '0;
      tasa <= pcnt_inc;
    end else begin
      wcnt <= wcnt + WCW'(1);
      pcnt <= pcnt_inc;
    end
  end
`endif
endmodule

// File: tb/tb_caudal_dosificador.sv
// Randomized bench for caudal_dosificador against an integer-arithmetic dosing model.
module tb_caudal_dosificador;
  localparam int REP = 0, MID = 1, COM = 2;

  logic        clk = 1'b0, rst_n = 1'b0, pulso_in = 1'b0;
  logic        borrar = 1'b0, inicio = 1'b0, detener = 1'b0;
  logic [15:0] consigna = '0, mililitros;
  logic        valvula, completo, desborde;
  logic        borrar_b = 1'b0, inicio_b = 1'b0, detener_b = 1'b0;
  logic [7:0]  consigna_b = '0, mililitros_b;
  logic        valvula_b, completo_b, desborde_b;
`ifdef CAUDAL_TASA_EN
  logic [15:0] tasa, tasa_b;
`endif

  always #5 clk = ~clk;

  caudal_dosificador #(.WINDOW_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .pulso_in(pulso_in), .borrar(borrar), .inicio(inicio),
    .detener(detener), .consigna(consigna), .mililitros(mililitros), .valvula(valvula),
    .completo(completo), .desborde(desborde)
`ifdef CAUDAL_TASA_EN
    , .tasa(tasa)
`endif
  );

  caudal_dosificador #(.DIGITS(2), .ML_PER_PULSE(9), .WINDOW_CYCLES(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulso_in(pulso_in), .borrar(borrar_b), .inicio(inicio_b),
    .detener(detener_b), .consigna(consigna_b), .mililitros(mililitros_b), .valvula(valvula_b),
    .completo(completo_b), .desborde(desborde_b)
`ifdef CAUDAL_TASA_EN
    , .tasa(tasa_b)
`endif
  );

  int total = 0, bad = 0;
  // Model: binary millilitre totals, dose mode and setpoint as plain integers.
  int m_tot = 0, m_sp = 0, m_mode = REP, b_tot = 0;
  bit m_desb = 0, b_desb = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] c);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(c[i*4 +: 4]);
    return v;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] c);
    bit ok;
    ok = 1;
    for (int i = 0; i < 4; i++) if (c[i*4 +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  task automatic b_add();
    if (b_tot + 9 > 99) begin b_tot = 99; b_desb = 1; end
    else b_tot += 9;
  endtask

  task automatic m_pulse();
    if (m_tot + 2 > 9999) begin m_tot = 9999; m_desb = 1; end
    else m_tot += 2;
    b_add();
    if (m_mode == MID && (m_desb || m_tot >= m_sp)) m_mode = COM;
  endtask

  task automatic m_inicio(input logic [15:0] c);
    if (bcd_ok(c) && m_mode != MID) begin
      m_sp = from_bcd(c);
      m_tot = 0;
      m_desb = 0;
      m_mode = (m_sp == 0) ? COM : MID;
    end
  endtask

  task automatic check_all(input string t);
    chk({t, "_ml"}, 32'(mililitros), 32'(to_bcd(m_tot)));
    chk({t, "_valv"}, 32'(valvula), 32'(m_mode == MID));
    chk({t, "_comp"}, 32'(completo), 32'(m_mode == COM));
    chk({t, "_desb"}, 32'(desborde), 32'(m_desb));
    chk({t, "_ml_b"}, 32'(mililitros_b), 32'(to_bcd(b_tot)));
    chk({t, "_desb_b"}, 32'(desborde_b), 32'(b_desb));
  endtask

  // One pulse; the total must move exactly on the third edge after the rise,
  // and the FSM reacts one edge later.
  task automatic pulse_chk(input int lo);
    logic [15:0] pre_t;
    logic        pre_v;
    pre_t = to_bcd(m_tot);
    pre_v = (m_mode == MID);
    m_pulse();
    @(posedge clk); #1 pulso_in = 1'b1;
    @(posedge clk); #1 chk("e1_ml", 32'(mililitros), 32'(pre_t));
    @(posedge clk); #1 pulso_in = 1'b0;
    chk("e2_ml", 32'(mililitros), 32'(pre_t));
    @(posedge clk); #1 chk("e3_ml", 32'(mililitros), 32'(to_bcd(m_tot)));
    chk("e3_valv", 32'(valvula), 32'(pre_v));
    @(posedge clk); #1 chk("e4_valv", 32'(valvula), 32'(m_mode == MID));
    chk("e4_comp", 32'(completo), 32'(m_mode == COM));
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // which: 0 borrar, 1 inicio, 2 detener
  task automatic ctrl(input int which, input logic [15:0] c);
    @(posedge clk); #1 consigna = c;
    case (which)
      0: borrar = 1'b1;
      1: inicio = 1'b1;
      default: detener = 1'b1;
    endcase
    @(posedge clk); #1 borrar = 1'b0; inicio = 1'b0; detener = 1'b0;
    @(posedge clk); #1;
    case (which)
      0: begin m_tot = 0; m_desb = 0; m_mode = REP; end
      1: m_inicio(c);
      default: if (m_mode != REP) m_mode = REP;
    endcase
  endtask

  initial begin
    logic [15:0] c;
    int r;

    #12 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) pulse_chk(1);
    chk("five_pulses", 32'(mililitros), 32'h0010);
    check_all("five");

    // Dose to 0x0010, then an extra pulse past the setpoint.
    ctrl(0, '0);
    ctrl(1, 16'h0010);
    check_all("dose_start");
    for (int i = 0; i < 5; i++) pulse_chk(0);
    chk("dose_done_comp", 32'(completo), 32'd1);
    pulse_chk(1);
    chk("dose_extra_ml", 32'(mililitros), 32'h0012);
    chk("dose_extra_comp", 32'(completo), 32'd1);

    // Abort then restart.
    ctrl(1, 16'h0100);
    for (int i = 0; i < 3; i++) pulse_chk(0);
    ctrl(2, '0);
    chk("det_ml", 32'(mililitros), 32'h0006);
    chk("det_valv", 32'(valvula), 32'd0);
    check_all("det");
    ctrl(1, 16'h0100);
    chk("restart_ml", 32'(mililitros), 32'h0000);
    chk("restart_valv", 32'(valvula), 32'd1);

    // Randomized operation mix.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) pulse_chk(int'($urandom_range(0, 2)));
      else if (r < 82) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) begin c = '0; c[7:4] = 4'($urandom_range(10, 15)); end
        else if (r == 1) c = '0;
        else c = to_bcd(int'($urandom_range(1, 40)));
        ctrl(1, c);
      end else if (r < 92) ctrl(2, '0);
      else ctrl(0, '0);
      check_all("rnd");
    end

    // Edge arriving together with borrar is lost.
    ctrl(1, 16'h0100);
    pulse_chk(0);
    @(posedge clk); #1 pulso_in = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 pulso_in = 1'b0; borrar = 1'b1;
    @(posedge clk); #1 borrar = 1'b0;
    m_tot = 0; m_desb = 0; m_mode = REP;
    b_add();
    chk("borrar_edge_ml", 32'(mililitros), 32'h0000);
    repeat (3) @(posedge clk);
    #1 check_all("borrar_edge");

    // Asynchronous reset mid-dose drops the valve without a clock edge.
    ctrl(1, 16'h0100);
    chk("pre_rst_valv", 32'(valvula), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_async_valv", 32'(valvula), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    m_tot = 0; m_desb = 0; m_mode = REP; m_sp = 0; b_tot = 0; b_desb = 0;
    check_all("post_rst");

    ctrl(1, 16'h00A0);
    chk("bad_sp_valv", 32'(valvula), 32'd0);
    check_all("bad_sp");

    // Two-digit, 9 ml/pulse instance: carries and saturation boundary.
    for (int i = 0; i < 11; i++) pulse_chk(0);
    chk("b11_ml", 32'(mililitros_b), 32'h99);
    chk("b11_desb", 32'(desborde_b), 32'd0);
    pulse_chk(0);
    chk("b12_ml", 32'(mililitros_b), 32'h99);
    chk("b12_desb", 32'(desborde_b), 32'd1);

    // Four-digit saturation ends the dose.
    ctrl(1, 16'h9999);
    for (int i = 0; i < 4999; i++) pulse_chk(0);
    chk("sat_pre_ml", 32'(mililitros), 32'h9998);
    chk("sat_pre_comp", 32'(completo), 32'd0);
    pulse_chk(1);
    chk("sat_ml", 32'(mililitros), 32'h9999);
    chk("sat_desb", 32'(desborde), 32'd1);
    chk("sat_comp", 32'(completo), 32'd1);
    pulse_chk(1);
    check_all("sat_hold");
    ctrl(1, 16'h0010);
    chk("sat_clr_desb", 32'(desborde), 32'd0);
    check_all("sat_clr");

`ifdef CAUDAL_TASA_EN
    ctrl(0, '0);
    chk("tasa_clr", 32'(tasa), 32'd0);
    for (int i = 0; i < 7; i++) pulse_chk(0);
    repeat (80) @(posedge clk);
    #1 chk("tasa_7", 32'(tasa), 32'd7);
    repeat (100) @(posedge clk);
    #1 chk("tasa_0", 32'(tasa), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
